// File: rtl/spi_apb_arbiter_pkg.sv
// spi_apb_arbiter_pkg
// Shared types and constants for the two-client APB arbiter in front of the
// SPI block's register port.
//   arb_state_e : APB master FSM state (IDLE, SETUP, ACCESS)
//   apb_req_t   : one client register transaction (addr, write, wdata, strb)
//   ADDR_*      : SPI register map offsets
package spi_apb_arbiter_pkg;

   localparam int unsigned SPI_ADDR_W = 5;
   localparam int unsigned SPI_DATA_W = 32;

   // Wide enough for any legal TIMEOUT (1..255).
   localparam int unsigned TO_CNT_W = 8;

   localparam logic [SPI_ADDR_W-1:0] ADDR_CR    = 5'h00;
   localparam logic [SPI_ADDR_W-1:0] ADDR_BR    = 5'h04;
   localparam logic [SPI_ADDR_W-1:0] ADDR_INTER = 5'h08;
   localparam logic [SPI_ADDR_W-1:0] ADDR_SR    = 5'h0C;
   localparam logic [SPI_ADDR_W-1:0] ADDR_RINTR = 5'h10;
   localparam logic [SPI_ADDR_W-1:0] ADDR_INTR  = 5'h14;
   localparam logic [SPI_ADDR_W-1:0] ADDR_TFIFO = 5'h18;
   localparam logic [SPI_ADDR_W-1:0] ADDR_RFIFO = 5'h1C;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } arb_state_e;

   typedef struct packed {
      logic [SPI_ADDR_W-1:0] addr;
      logic                  write;
      logic [SPI_DATA_W-1:0] wdata;
      logic [3:0]            strb;
   } apb_req_t;

endpackage

// File: rtl/spi_apb_arbiter_rr_arb2.sv
// spi_apb_rr_arb2
// Two-way round-robin pick. r_prio names the preferred client when both
// request; after every accepted grant the other client becomes preferred.
//   i_clk, i_rst : clock, asynchronous active-high reset (prio -> 0)
//   i_valid      : request vector {client1, client0}
//   i_advance    : the current grant was taken this cycle
//   o_grant      : one-hot grant (zero when nobody requests)
module spi_apb_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_valid,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_prio;

   always_comb begin
      o_grant = i_valid;
      if (i_valid == 2'b11) begin
         o_grant = r_prio ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         // Granted client 0 -> prefer 1 next, and vice versa.
         r_prio <= o_grant[0];
      end
   end

endmodule

// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter
// Shares the SPI APB slave port between two clients. A request is accepted in
// IDLE (combinational ready), then a SETUP and one or more ACCESS cycles run on
// APB. Completion on pready, or forced error after TIMEOUT wait cycles, pulses
// the granted client's rsp_valid with registered rdata/err.
//   i_pclk, i_preset          : clock, asynchronous active-high reset
//   i_reqN_*  / o_reqN_ready  : client N request port (valid/ready)
//   o_rspN_*                  : client N response (valid pulse, rdata, err)
//   o_psel..o_pstrb, i_prdata, i_pready, i_pslverr : APB master
//   o_busy                    : FSM not in IDLE
module spi_apb_arbiter
   import spi_apb_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              i_pclk,
   input  logic              i_preset,
   input  logic              i_req0_valid,
   input  logic [ADDR_W-1:0] i_req0_addr,
   input  logic              i_req0_write,
   input  logic [DATA_W-1:0] i_req0_wdata,
   input  logic [3:0]        i_req0_strb,
   output logic              o_req0_ready,
   input  logic              i_req1_valid,
   input  logic [ADDR_W-1:0] i_req1_addr,
   input  logic              i_req1_write,
   input  logic [DATA_W-1:0] i_req1_wdata,
   input  logic [3:0]        i_req1_strb,
   output logic              o_req1_ready,
   output logic              o_rsp0_valid,
   output logic [DATA_W-1:0] o_rsp0_rdata,
   output logic              o_rsp0_err,
   output logic              o_rsp1_valid,
   output logic [DATA_W-1:0] o_rsp1_rdata,
   output logic              o_rsp1_err,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   output logic [3:0]        o_pstrb,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready,
   input  logic              i_pslverr,
   output logic              o_busy
);

   localparam logic [TO_CNT_W-1:0] TIMEOUT_C = TO_CNT_W'(TIMEOUT);

   arb_state_e          r_state;
   logic [TO_CNT_W-1:0] r_cnt;
   logic                r_gnt1;
   logic                r_psel, r_penable, r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic [3:0]          r_pstrb;
   logic                r_rsp0_valid, r_rsp0_err, r_rsp1_valid, r_rsp1_err;
   logic [DATA_W-1:0]   r_rsp0_rdata, r_rsp1_rdata;

   logic [1:0]          w_grant;
   logic                w_take, w_done, w_err;
   logic [DATA_W-1:0]   w_rdata;

   // Ready is gated by reset so no handshake can complete while held in reset.
   assign w_take = (r_state == StIdle) && !i_preset && (i_req0_valid || i_req1_valid);

   spi_apb_rr_arb2 u_arb (
      .i_clk     (i_pclk),
      .i_rst     (i_preset),
      .i_valid   ({i_req1_valid, i_req0_valid}),
      .i_advance (w_take),
      .o_grant   (w_grant)
   );

   // pready wins over timeout; a timeout always reports err with zero data.
   assign w_done  = (r_state == StAccess) && (i_pready || (r_cnt == TIMEOUT_C));
   assign w_err   = i_pready ? i_pslverr : 1'b1;
   assign w_rdata = (i_pready && !r_pwrite) ? i_prdata : '0;

   always_ff @(posedge i_pclk or posedge i_preset) begin
      if (i_preset) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_gnt1       <= 1'b0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_pstrb      <= '0;
         r_rsp0_valid <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp0_err   <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp1_rdata <= '0;
         r_rsp1_err   <= 1'b0;
      end else begin
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_take) begin
                  r_gnt1   <= w_grant[1];
                  r_paddr  <= w_grant[1] ? i_req1_addr  : i_req0_addr;
                  r_pwrite <= w_grant[1] ? i_req1_write : i_req0_write;
                  r_pwdata <= w_grant[1] ? i_req1_wdata : i_req0_wdata;
                  r_pstrb  <= w_grant[1] ? i_req1_strb  : i_req0_strb;
                  r_psel   <= 1'b1;
                  r_state  <= StSetup;
               end
            end
            StSetup: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= StAccess;
            end
            StAccess: begin
               if (w_done) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= StIdle;
                  if (r_gnt1) begin
                     r_rsp1_valid <= 1'b1;
                     r_rsp1_rdata <= w_rdata;
                     r_rsp1_err   <= w_err;
                  end else begin
                     r_rsp0_valid <= 1'b1;
                     r_rsp0_rdata <= w_rdata;
                     r_rsp0_err   <= w_err;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req0_ready = w_take && w_grant[0];
   assign o_req1_ready = w_take && w_grant[1];
   assign o_rsp0_valid = r_rsp0_valid;
   assign o_rsp0_rdata = r_rsp0_rdata;
   assign o_rsp0_err   = r_rsp0_err;
   assign o_rsp1_valid = r_rsp1_valid;
   assign o_rsp1_rdata = r_rsp1_rdata;
   assign o_rsp1_err   = r_rsp1_err;
   assign o_psel       = r_psel;
   assign o_penable    = r_penable;
   assign o_pwrite     = r_pwrite;
   assign o_paddr      = r_paddr;
   assign o_pwdata     = r_pwdata;
   assign o_pstrb      = r_pstrb;
   assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// tb_spi_apb_arbiter
// Directed bench for spi_apb_arbiter: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_spi_apb_arbiter;
   import spi_apb_arbiter_pkg::*;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid, req_write, ready, rsp_valid, rsp_err;
   logic [4:0]  req_addr [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_strb [2];
   logic [31:0] rsp_rdata [2];
   logic        psel, penable, pwrite, pready, pslverr, busy;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;

   int n_checks = 0;
   int n_errors = 0;

   spi_apb_arbiter #(
      .ADDR_W  (5),
      .DATA_W  (32),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_pclk       (clk),
      .i_preset     (rst),
      .i_req0_valid (req_valid[0]),
      .i_req0_addr  (req_addr[0]),
      .i_req0_write (req_write[0]),
      .i_req0_wdata (req_wdata[0]),
      .i_req0_strb  (req_strb[0]),
      .o_req0_ready (ready[0]),
      .i_req1_valid (req_valid[1]),
      .i_req1_addr  (req_addr[1]),
      .i_req1_write (req_write[1]),
      .i_req1_wdata (req_wdata[1]),
      .i_req1_strb  (req_strb[1]),
      .o_req1_ready (ready[1]),
      .o_rsp0_valid (rsp_valid[0]),
      .o_rsp0_rdata (rsp_rdata[0]),
      .o_rsp0_err   (rsp_err[0]),
      .o_rsp1_valid (rsp_valid[1]),
      .o_rsp1_rdata (rsp_rdata[1]),
      .o_rsp1_err   (rsp_err[1]),
      .o_psel       (psel),
      .o_penable    (penable),
      .o_pwrite     (pwrite),
      .o_paddr      (paddr),
      .o_pwdata     (pwdata),
      .o_pstrb      (pstrb),
      .i_prdata     (prdata),
      .i_pready     (pready),
      .i_pslverr    (pslverr),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a falling edge with the FSM in IDLE. Runs one transaction of
   // client c; the slave inserts `waits` wait states (waits > TIMEOUT means
   // pready never comes). Returns at the falling edge of the response cycle.
   task automatic run_txn(input int c, input logic [4:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] st, input int waits,
                          input logic [31:0] rd, input logic se,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit keep, input string tag);
      int n_acc;
      req_valid[c] = 1'b1;
      req_addr[c]  = a;
      req_write[c] = w;
      req_wdata[c] = wd;
      req_strb[c]  = st;
      #1;
      check({tag, ".ready"}, ready[c], 1);
      check({tag, ".ready_other"}, ready[1-c], 0);
      @(negedge clk);
      if (!keep) req_valid[c] = 1'b0;
      #1;
      check({tag, ".setup_sel_en"}, {psel, penable}, 2'b10);
      check({tag, ".setup_addr"}, paddr, a);
      check({tag, ".setup_write"}, pwrite, w);
      check({tag, ".setup_wdata"}, pwdata, wd);
      check({tag, ".setup_strb"}, pstrb, st);
      check({tag, ".setup_busy"}, busy, 1);
      n_acc = (waits > TIMEOUT) ? TIMEOUT + 1 : waits + 1;
      for (int k = 0; k < n_acc; k++) begin
         @(negedge clk);
         pready  = (k == waits);
         prdata  = rd;
         pslverr = se;
         #1;
         check({tag, ".acc_sel_en"}, {psel, penable}, 2'b11);
         check({tag, ".acc_addr"}, paddr, a);
         check({tag, ".acc_wdata"}, pwdata, wd);
         check({tag, ".acc_no_rsp"}, rsp_valid, 2'b00);
      end
      @(negedge clk);
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      #1;
      check({tag, ".rsp_valid"}, rsp_valid, 2'b01 << c);
      check({tag, ".rsp_rdata"}, rsp_rdata[c], exp_rd);
      check({tag, ".rsp_err"}, rsp_err[c], exp_err);
      check({tag, ".idle_sel_en"}, {psel, penable}, 2'b00);
      check({tag, ".idle_busy"}, busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 2'b00;
      req_write = 2'b00;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_strb[i]  = '0;
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;

      // Reset state, with a request pending to show ready stays low.
      @(negedge clk);
      req_valid[0] = 1'b1;
      @(negedge clk);
      #1;
      check("rst.ready", ready, 2'b00);
      check("rst.sel_en", {psel, penable}, 2'b00);
      check("rst.busy", busy, 0);
      check("rst.rsp_valid", rsp_valid, 2'b00);
      check("rst.paddr", paddr, 0);
      check("rst.pstrb", pstrb, 0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single zero-wait write.
      run_txn(0, ADDR_BR, 1'b1, 32'h14, 4'hF, 0, 32'hBAD0, 1'b0, 32'h0, 1'b0, 1'b0, "wr0");
      @(negedge clk);
      #1;
      check("wr0.pulse_once", rsp_valid, 2'b00);
      check("wr0.paddr_hold", paddr, ADDR_BR);

      // Reset again so prio is known to be 0, then contention: 0,1,0,1.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      req_write = 2'b00;
      req_addr[0] = ADDR_CR;
      req_addr[1] = ADDR_SR;
      run_txn(0, ADDR_CR, 1'b0, 32'h0, 4'hF, 0, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, "ct0a");
      run_txn(1, ADDR_SR, 1'b0, 32'h0, 4'hF, 0, 32'h4, 1'b0, 32'h4, 1'b0, 1'b1, "ct1a");
      run_txn(0, ADDR_CR, 1'b0, 32'h0, 4'hF, 0, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, "ct0b");
      run_txn(1, ADDR_SR, 1'b0, 32'h0, 4'hF, 0, 32'h4, 1'b0, 32'h4, 1'b0, 1'b0, "ct1b");
      req_valid = 2'b00;
      #1;
      check("ct.rsp0_hold", rsp_rdata[0], 32'h1);
      @(negedge clk);

      // Three wait states on a read of SR (prio is 0 here).
      run_txn(1, ADDR_SR, 1'b0, 32'h0, 4'h3, 3, 32'h4, 1'b0, 32'h4, 1'b0, 1'b0, "wait3");
      // Slave error on a write.
      run_txn(0, ADDR_SR, 1'b1, 32'hA5, 4'h1, 0, 32'h77, 1'b1, 32'h0, 1'b1, 1'b0, "slverr");
      @(negedge clk);
      // Timeout: pready never comes; rdata forced to 0.
      run_txn(1, ADDR_RFIFO, 1'b0, 32'h0, 4'hF, 99, 32'hDEAD, 1'b0, 32'h0, 1'b1, 1'b0, "tmo");
      // pready in the 16th and 17th ACCESS cycle completes normally.
      run_txn(0, ADDR_TFIFO, 1'b0, 32'h0, 4'hF, 15, 32'h55, 1'b0, 32'h55, 1'b0, 1'b0, "tmo15");
      run_txn(1, ADDR_INTR, 1'b0, 32'h0, 4'hF, 16, 32'h66, 1'b0, 32'h66, 1'b0, 1'b0, "tmo16");
      @(negedge clk);

      // Reset mid-ACCESS: client 0 granted alone (prio -> 1), then reset.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = ADDR_INTER;
      #1;
      check("mid.ready", ready[0], 1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_addr[1]  = ADDR_SR;
      req_write[1] = 1'b0;
      #2;
      check("mid.pre_sel_en", {psel, penable}, 2'b11);
      rst = 1'b1;
      #1;
      check("mid.sel_en", {psel, penable}, 2'b00);
      check("mid.busy", busy, 0);
      check("mid.ready", ready, 2'b00);
      check("mid.rdata_clr", rsp_rdata[0], 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check("mid.no_rsp", rsp_valid, 2'b00);
      end
      rst = 1'b0;
      // Both requesting: prio was cleared, so client 0 wins.
      run_txn(0, ADDR_CR, 1'b0, 32'h0, 4'hF, 0, 32'h9, 1'b0, 32'h9, 1'b0, 1'b0, "post0");
      run_txn(1, ADDR_SR, 1'b0, 32'h0, 4'hF, 1, 32'h4, 1'b0, 32'h4, 1'b0, 1'b0, "post1");
      @(negedge clk);
      #1;
      check("end.rsp_valid", rsp_valid, 2'b00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
